// File: rtl/modulo_controlador_reservatorio_rolhas.sv
// Cork inventory controller: arbitrates operator loads, reservoir-to-feeder
// batch transfers and per-bottle consumption over two saturating counts.
module modulo_controlador_reservatorio_rolhas #(
    parameter int W         = 7,
    parameter int MAX_SEC   = 99,
    parameter int MAX_PRINC = 20,
    parameter int MIN_PRINC = 5,
    parameter int LOTE      = 15
) (
    input  logic         clk,
    input  logic         Nclr,
    input  logic         en,
    input  logic         add_req,
    input  logic [W-1:0] add_val,
    input  logic         ve_pulse,
    output logic [W-1:0] reg_secundario,
    output logic [W-1:0] reg_principal,
    output logic         ro,
    output logic         min_signal,
    output logic         busy,
    output logic         add_ack,
    output logic         add_err,
    output logic         falta
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADD      = 2'd1,
        TRANSFER = 2'd2
    } state_t;

    localparam logic [W:0]   MAX_SEC_W   = (W+1)'(MAX_SEC);
    localparam logic [W-1:0] MAX_PRINC_W = W'(MAX_PRINC);
    localparam logic [W-1:0] MIN_PRINC_W = W'(MIN_PRINC);
    localparam logic [W-1:0] LOTE_W      = W'(LOTE);
    localparam logic [W-1:0] ONE         = W'(1);

    state_t       state, state_next;
    logic         add_req_q;
    logic         add_pending;
    logic [W-1:0] add_value;
    logic [W-1:0] transfer_cnt;

    logic         add_rise;
    logic [W:0]   add_sum;
    logic         add_ok;
    logic         start_transfer;
    logic         move;
    logic [W-1:0] princ_after_move;
    logic         transfer_done;

    assign ro         = (reg_principal == '0);
    assign min_signal = (reg_principal < MIN_PRINC_W);
    assign busy       = (state != IDLE);

    assign add_rise = add_req & ~add_req_q;
    // Extra bit keeps the capacity test honest when the sum would wrap.
    assign add_sum  = {1'b0, reg_secundario} + {1'b0, add_value};
    assign add_ok   = (add_value != '0) && (add_sum <= MAX_SEC_W);

    assign start_transfer = en && min_signal && (reg_secundario != '0)
                            && (reg_principal < MAX_PRINC_W);
    assign move = (state == TRANSFER) && (reg_secundario != '0)
                  && (reg_principal < MAX_PRINC_W);
    // A simultaneous consumption cancels the feeder increment of the move.
    assign princ_after_move = ve_pulse ? reg_principal : reg_principal + ONE;
    assign transfer_done = !move || !en || (transfer_cnt + ONE == LOTE_W)
                           || (reg_secundario == ONE)
                           || (princ_after_move == MAX_PRINC_W);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_transfer)
                    state_next = TRANSFER;
                else if (add_pending)
                    state_next = ADD;
            end
            ADD:      state_next = IDLE;
            TRANSFER: if (transfer_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            state          <= IDLE;
            add_req_q      <= 1'b0;
            add_pending    <= 1'b0;
            add_value      <= '0;
            transfer_cnt   <= '0;
            reg_secundario <= '0;
            reg_principal  <= '0;
            add_ack        <= 1'b0;
            add_err        <= 1'b0;
            falta          <= 1'b0;
        end else begin
            state     <= state_next;
            add_req_q <= add_req;
            add_ack   <= 1'b0;
            add_err   <= 1'b0;
            falta     <= 1'b0;

            if (state == ADD) begin
                add_pending <= 1'b0;
                if (add_ok) begin
                    reg_secundario <= add_sum[W-1:0];
                    add_ack        <= 1'b1;
                end else begin
                    add_err <= 1'b1;
                end
            end else if (add_rise && !add_pending) begin
                add_pending <= 1'b1;
                add_value   <= add_val;
            end

            if (state == IDLE && start_transfer)
                transfer_cnt <= '0;

            if (move) begin
                reg_secundario <= reg_secundario - ONE;
                reg_principal  <= princ_after_move;
                transfer_cnt   <= transfer_cnt + ONE;
            end else if (ve_pulse && reg_principal != '0) begin
                reg_principal <= reg_principal - ONE;
            end else if (ve_pulse) begin
                falta <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modulo_controlador_reservatorio_rolhas.sv
// Self-checking bench: a cycle-level inventory model is compared against the
// controller every cycle, with directed scenarios pinning literal results.
module tb_modulo_controlador_reservatorio_rolhas;

    logic       clk = 1'b0;
    logic       Nclr = 1'b0;
    logic       en = 1'b0;
    logic       add_req = 1'b0;
    logic [6:0] add_val = '0;
    logic       ve_pulse = 1'b0;
    logic [6:0] reg_secundario, reg_principal;
    logic       ro, min_signal, busy, add_ack, add_err, falta;

    int checks = 0;
    int errors = 0;

    // Reference inventory: phase 0 = waiting, 1 = serving a load, 2 = moving corks.
    int m_sec = 0, m_princ = 0, m_phase = 0, m_moved = 0, m_val = 0;
    bit m_pend = 0, m_prev = 0, m_ack = 0, m_err = 0, m_falta = 0;

    int ack_seen = 0, err_seen = 0, falta_seen = 0, busy_seen = 0;

    modulo_controlador_reservatorio_rolhas dut (
        .clk(clk), .Nclr(Nclr), .en(en), .add_req(add_req), .add_val(add_val),
        .ve_pulse(ve_pulse), .reg_secundario(reg_secundario),
        .reg_principal(reg_principal), .ro(ro), .min_signal(min_signal),
        .busy(busy), .add_ack(add_ack), .add_err(add_err), .falta(falta)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // The model advances once per clock edge using the same sampled inputs.
    always @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            m_sec = 0; m_princ = 0; m_phase = 0; m_moved = 0; m_val = 0;
            m_pend = 0; m_prev = 0; m_ack = 0; m_err = 0; m_falta = 0;
        end else begin
            bit rise, pend_old, did_move;
            rise = add_req && !m_prev;
            m_prev = add_req;
            pend_old = m_pend;
            m_ack = 0; m_err = 0; m_falta = 0;
            did_move = 0;
            case (m_phase)
                0: begin
                    if (en && m_princ < 5 && m_sec > 0) begin
                        m_phase = 2;
                        m_moved = 0;
                    end else if (pend_old) begin
                        m_phase = 1;
                    end
                    if (rise && !pend_old) begin
                        m_pend = 1;
                        m_val = int'(add_val);
                    end
                end
                1: begin
                    if (m_val == 0 || m_sec + m_val > 99) m_err = 1;
                    else begin
                        m_sec = m_sec + m_val;
                        m_ack = 1;
                    end
                    m_pend = 0;
                    m_phase = 0;
                end
                default: begin
                    did_move = 1;
                    m_sec = m_sec - 1;
                    m_moved = m_moved + 1;
                    if (!ve_pulse) m_princ = m_princ + 1;
                    if (m_moved == 15 || m_sec == 0 || m_princ == 20 || !en)
                        m_phase = 0;
                    if (rise && !pend_old) begin
                        m_pend = 1;
                        m_val = int'(add_val);
                    end
                end
            endcase
            if (ve_pulse && !did_move) begin
                if (m_princ > 0) m_princ = m_princ - 1;
                else m_falta = 1;
            end
        end
    end

    // Every cycle, shortly after the edge, the outputs must match the model.
    always @(posedge clk) begin
        #2;
        checkOutput("reg_secundario", int'(reg_secundario), m_sec);
        checkOutput("reg_principal", int'(reg_principal), m_princ);
        checkOutput("ro", int'(ro), int'(m_princ == 0));
        checkOutput("min_signal", int'(min_signal), int'(m_princ < 5));
        checkOutput("busy", int'(busy), int'(m_phase != 0));
        checkOutput("add_ack", int'(add_ack), int'(m_ack));
        checkOutput("add_err", int'(add_err), int'(m_err));
        checkOutput("falta", int'(falta), int'(m_falta));
        ack_seen   += int'(add_ack);
        err_seen   += int'(add_err);
        falta_seen += int'(falta);
        busy_seen  += int'(busy);
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        Nclr = 1'b0; en = 1'b0; add_req = 1'b0; add_val = '0; ve_pulse = 1'b0;
        waitCycles(2);
        Nclr = 1'b1;
        waitCycles(1);
    endtask

    task automatic applyStimulus(input int val);
        @(negedge clk);
        add_val = 7'(val);
        add_req = 1'b1;
        @(negedge clk);
        add_req = 1'b0;
        waitCycles(4);
    endtask

    initial begin
        int a0, e0, f0, b0;
        resetDut();
        checkOutput("reset reg_secundario", int'(reg_secundario), 0);
        checkOutput("reset reg_principal", int'(reg_principal), 0);
        checkOutput("reset ro", int'(ro), 1);
        checkOutput("reset min_signal", int'(min_signal), 1);
        checkOutput("reset busy", int'(busy), 0);

        // Load 40 with the request held high for 10 cycles: one ack only.
        a0 = ack_seen;
        @(negedge clk);
        add_val = 7'd40;
        add_req = 1'b1;
        waitCycles(10);
        add_req = 1'b0;
        waitCycles(3);
        checkOutput("held load count", int'(reg_secundario), 40);
        checkOutput("held load acks", ack_seen - a0, 1);

        // Capacity boundary around 99 and the zero-load rejection.
        e0 = err_seen;
        applyStimulus(50);
        checkOutput("load to 90", int'(reg_secundario), 90);
        applyStimulus(10);
        checkOutput("overflow rejected", int'(reg_secundario), 90);
        applyStimulus(9);
        checkOutput("load to 99", int'(reg_secundario), 99);
        applyStimulus(0);
        checkOutput("zero load rejected", int'(reg_secundario), 99);
        checkOutput("reject count", err_seen - e0, 2);

        // Full batch of 15 from a reservoir of 40.
        resetDut();
        applyStimulus(40);
        b0 = busy_seen;
        en = 1'b1;
        waitCycles(20);
        checkOutput("batch reservoir", int'(reg_secundario), 25);
        checkOutput("batch feeder", int'(reg_principal), 15);
        checkOutput("batch busy cycles", busy_seen - b0, 15);
        checkOutput("batch idle", int'(busy), 0);

        // Short batch limited by an emptied reservoir.
        resetDut();
        applyStimulus(7);
        en = 1'b1;
        waitCycles(12);
        checkOutput("short reservoir", int'(reg_secundario), 0);
        checkOutput("short feeder", int'(reg_principal), 7);

        // Consumption and a load request overlapping a batch.
        resetDut();
        applyStimulus(3);
        en = 1'b1;
        waitCycles(6);
        checkOutput("prefill feeder", int'(reg_principal), 3);
        en = 1'b0;
        applyStimulus(40);
        a0 = ack_seen;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        @(negedge clk); ve_pulse = 1'b1;
        @(negedge clk); ve_pulse = 1'b0;
        @(negedge clk); ve_pulse = 1'b1;
        @(negedge clk); ve_pulse = 1'b0;
        @(negedge clk); add_val = 7'd5; add_req = 1'b1;
        @(negedge clk);
        @(negedge clk); add_req = 1'b0;
        waitCycles(20);
        checkOutput("overlap feeder", int'(reg_principal), 16);
        checkOutput("overlap reservoir", int'(reg_secundario), 30);
        checkOutput("overlap acks", ack_seen - a0, 1);

        // Empty feeder consumption raises falta exactly once.
        resetDut();
        f0 = falta_seen;
        b0 = busy_seen;
        en = 1'b1;
        @(negedge clk); ve_pulse = 1'b1;
        @(negedge clk); ve_pulse = 1'b0;
        waitCycles(3);
        checkOutput("falta pulses", falta_seen - f0, 1);
        checkOutput("empty feeder", int'(reg_principal), 0);
        checkOutput("no transfer when empty", busy_seen - b0, 0);

        // Feeder above threshold blocks transfers; refill tops out at 19.
        resetDut();
        applyStimulus(99);
        en = 1'b1;
        waitCycles(20);
        en = 1'b0;
        repeat (11) begin
            @(negedge clk); ve_pulse = 1'b1;
        end
        @(negedge clk); ve_pulse = 1'b0;
        checkOutput("drained feeder", int'(reg_principal), 4);
        en = 1'b1;
        waitCycles(20);
        checkOutput("refill feeder", int'(reg_principal), 19);
        checkOutput("refill reservoir", int'(reg_secundario), 69);
        checkOutput("full min_signal", int'(min_signal), 0);
        checkOutput("full idle", int'(busy), 0);

        // Asynchronous reset in the middle of a batch.
        resetDut();
        applyStimulus(40);
        en = 1'b1;
        waitCycles(5);
        checkOutput("mid batch busy", int'(busy), 1);
        @(posedge clk);
        #3 Nclr = 1'b0;
        #1;
        checkOutput("async reset reservoir", int'(reg_secundario), 0);
        checkOutput("async reset feeder", int'(reg_principal), 0);
        checkOutput("async reset busy", int'(busy), 0);
        @(negedge clk);
        en = 1'b0;
        Nclr = 1'b1;
        waitCycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
